// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Index width for n entries; never below one bit so vectors stay legal.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping mod N.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req_i,
  input  logic [rr_idx_w(N)-1:0]  ptr_i,
  output logic [rr_idx_w(N)-1:0]  winner_o,
  output logic                    valid_o
);

  localparam int IW = rr_idx_w(N);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest hit to the pointer is written last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one registered grant at a time, bounded hold time, one dead cycle
// between owners so the shared resource always sees a clean handover.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 timeout
);

  localparam int            IW        = rr_idx_w(N);
  localparam int            HW        = rr_idx_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  arb_state_e    state_q;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q;
  logic          timeout_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          owner_req;
  logic          release_d;
  logic          expire_d;

  rr_priority_pick #(
    .N(N)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

  // A release always wins over the hold limit, so expiry requires the owner still requesting.
  always_comb begin
    gnt_d           = '0;
    gnt_d[pick_idx] = 1'b1;
    owner_req       = req[owner_q];
    release_d       = !owner_req;
    expire_d        = owner_req && (hold_cnt_q == HOLD_LAST);
    ptr_d           = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE, GAP: begin
          if (pick_vld) begin
            state_q    <= GRANT;
            gnt_q      <= gnt_d;
            busy_q     <= 1'b1;
            owner_q    <= pick_idx;
            hold_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_d || expire_d) begin
            state_q    <= GAP;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= ptr_d;
            timeout_q  <= expire_d;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign owner_id = owner_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: a transaction-level owner/pointer model checked every cycle,
// plus directed scenarios with literal expectations, on a MAX_HOLD=16 and a MAX_HOLD=1 instance.
module tb_rr_grant_arbiter;

  localparam int NREQ = 4;
  localparam int MH0  = 16;
  localparam int MH1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [3:0] req0, req1, gnt0, gnt1;
  logic       busy0, busy1, to0, to1;
  logic [1:0] oid0, oid1;

  rr_grant_arbiter #(.N(NREQ), .MAX_HOLD(MH0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .gnt(gnt0),
    .busy(busy0), .owner_id(oid0), .timeout(to0)
  );

  rr_grant_arbiter #(.N(NREQ), .MAX_HOLD(MH1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .gnt(gnt1),
    .busy(busy1), .owner_id(oid1), .timeout(to1)
  );

  int nvec = 0;
  int nmis = 0;

  // Model state per instance: current owner (-1 = nobody), cycles already granted, pointer.
  int         own   [2] = '{-1, -1};
  int         held  [2] = '{0, 0};
  int         ptr   [2] = '{0, 0};
  bit         tom   [2] = '{1'b0, 1'b0};
  int         mh    [2] = '{MH0, MH1};
  int         lat   [2] = '{(NREQ-1)*(MH0+1)+2, (NREQ-1)*(MH1+1)+2};
  logic [3:0] req_s [2] = '{4'b0000, 4'b0000};
  logic [3:0] pg    [2] = '{4'b0000, 4'b0000};
  int         wt    [2][4];

  logic [3:0] exp3 [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
  logic       to3  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] tbl  [8] = '{4'b1011, 4'b0110, 4'b1111, 4'b0001, 4'b1000, 4'b0101, 4'b1110, 4'b0000};
  int         dur  [8] = '{7, 20, 40, 3, 18, 25, 30, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mreset(input int m);
    own[m]   = -1;
    held[m]  = 0;
    ptr[m]   = 0;
    tom[m]   = 1'b0;
    req_s[m] = 4'b0000;
    pg[m]    = 4'b0000;
    for (int i = 0; i < NREQ; i++) wt[m][i] = 0;
  endtask

  // One clock of the arbitration rules: the owner leaves on release or after mh cycles,
  // otherwise a free arbiter picks the first request at or after the pointer.
  task automatic mstep(input int m, input logic [3:0] r);
    bit found;
    int c;
    req_s[m] = r;
    tom[m]   = 1'b0;
    if (own[m] >= 0) begin
      if (!r[own[m]]) begin
        ptr[m] = (own[m] + 1) % NREQ;
        own[m] = -1;
      end else if (held[m] == mh[m]) begin
        tom[m] = 1'b1;
        ptr[m] = (own[m] + 1) % NREQ;
        own[m] = -1;
      end else begin
        held[m]++;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        c = (ptr[m] + k) % NREQ;
        if (!found && r[c]) begin
          found   = 1'b1;
          own[m]  = c;
          held[m] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst0) if (rst0) mreset(0); else mstep(0, req0);
  always @(posedge clk or posedge rst1) if (rst1) mreset(1); else mstep(1, req1);

  task automatic cmp(input int m, input logic r, input logic [3:0] g, input logic b,
                     input logic [1:0] oid, input logic t);
    logic [3:0] eg;
    if (r) begin
      chk($sformatf("rst_gnt%0d", m), g, 4'b0000);
      chk($sformatf("rst_busy%0d", m), b, 1'b0);
      chk($sformatf("rst_timeout%0d", m), t, 1'b0);
      return;
    end
    eg = (own[m] >= 0) ? 4'(4'b0001 << own[m]) : 4'b0000;
    chk($sformatf("gnt%0d", m), g, eg);
    chk($sformatf("busy%0d", m), b, own[m] >= 0);
    chk($sformatf("timeout%0d", m), t, tom[m]);
    if (own[m] >= 0) chk($sformatf("owner_id%0d", m), oid, own[m]);
    chk($sformatf("onehot0_%0d", m), $onehot0(g), 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i] && !pg[m][i]) chk($sformatf("gnt_needs_req%0d_%0d", m, i), req_s[m][i], 1'b1);
      if (req_s[m][i] && !g[i]) wt[m][i]++;
      else wt[m][i] = 0;
      if (req_s[m][i]) chk($sformatf("latency%0d_%0d", m, i), wt[m][i] <= lat[m], 1'b1);
    end
    pg[m] = g;
  endtask

  always @(negedge clk) begin
    cmp(0, rst0, gnt0, busy0, oid0, to0);
    cmp(1, rst1, gnt1, busy1, oid1, to1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e;
    rst0 = 1'b1;
    rst1 = 1'b1;
    req0 = 4'b0000;
    req1 = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt0, 4'b0000);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_owner_id", oid0, 2'd0);
    chk("reset_timeout", to0, 1'b0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Single requester 2, released after five granted cycles.
    @(negedge clk);
    req0 = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t1_gnt", gnt0, 4'b0100);
      chk("t1_timeout", to0, 1'b0);
      if (c == 5) req0 = 4'b0000;
    end
    @(negedge clk);
    chk("t1_gap_gnt", gnt0, 4'b0000);
    chk("t1_gap_busy", busy0, 1'b0);
    chk("t1_gap_timeout", to0, 1'b0);
    req0 = 4'b1001;
    @(negedge clk);
    chk("t1_ptr3_gnt", gnt0, 4'b1000);
    chk("t1_ptr3_owner", oid0, 2'd3);
    req0 = 4'b0000;
    repeat (2) @(negedge clk);

    // All four requesting: 16-cycle grants, timeout in each gap, order 0,1,2,3,0.
    req0 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        chk("t2_gnt", gnt0, e);
        chk("t2_owner", oid0, g % 4);
        chk("t2_timeout", to0, 1'b0);
      end
      @(negedge clk);
      chk("t2_gap_gnt", gnt0, 4'b0000);
      chk("t2_gap_timeout", to0, 1'b1);
      if (g == 4) req0 = 4'b0000;
    end
    @(negedge clk);

    // Owner 2 releases on its last allowed cycle: release wins, no timeout.
    req0 = 4'b0100;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("t4_gnt", gnt0, 4'b0100);
      if (c == 16) req0 = 4'b0000;
    end
    @(negedge clk);
    chk("t4_gnt_clear", gnt0, 4'b0000);
    chk("t4_no_timeout", to0, 1'b0);

    // Reset in the middle of requester 1's grant, then restart from pointer 0.
    req0 = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("t5_gnt", gnt0, 4'b0010);
    end
    #2 rst0 = 1'b1;
    #1;
    chk("t5_async_gnt", gnt0, 4'b0000);
    chk("t5_async_busy", busy0, 1'b0);
    req0 = 4'b1010;
    @(negedge clk);
    #2 rst0 = 1'b0;
    @(negedge clk);
    chk("t5_regrant", gnt0, 4'b0010);
    chk("t5_regrant_owner", oid0, 2'd1);
    req0 = 4'b0000;
    repeat (3) @(negedge clk);

    // MAX_HOLD=1: alternating single-cycle grants, each ending in a timeout.
    req1 = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_gnt", gnt1, exp3[k]);
      chk("t3_timeout", to1, to3[k]);
      if (k == 4) req1 = 4'b0000;
    end
    @(negedge clk);
    chk("t3_release_at_limit_gnt", gnt1, 4'b0000);
    chk("t3_release_at_limit_timeout", to1, 1'b0);
    @(negedge clk);

    // Mixed request patterns on both instances; the per-cycle model does the checking.
    for (int t = 0; t < 8; t++) begin
      req0 = tbl[t];
      req1 = tbl[t];
      repeat (dur[t]) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
